// File: rtl/div_datapath.sv
// Datapath for a 4-bit unsigned restoring divider.
// Holds the divisor (Y), the dividend/quotient shifter (X), the 5-bit partial
// remainder (R) and an iteration counter; a separate control unit drives all
// strobes. Results are captured into output registers on done.
module div_datapath (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    input  logic       ld,
    input  logic       ud,
    input  logic       ce,
    input  logic       ldx,
    input  logic       slx,
    input  logic       srx,
    input  logic       cex,
    input  logic       ldr,
    input  logic       slr,
    input  logic       srr,
    input  logic       cer,
    input  logic       s1,
    input  logic       s2,
    input  logic       s3,
    input  logic       done,
    output logic       r_lt_y,
    output logic       count_equ_0,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    localparam int unsigned DW = 4;
    localparam int unsigned RW = DW + 1;

    logic [DW-1:0] r_y;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_x;
    logic [RW-1:0] r_r;

    logic [RW-1:0] w_y_ext;
    logic [RW-1:0] w_r_sub;
    logic          w_qbit;

    // Compare/subtract helpers and the quotient bit shifted into X
    always_comb begin
        w_y_ext     = {1'b0, r_y};
        w_r_sub     = r_r - w_y_ext;
        r_lt_y      = (r_r < w_y_ext);
        count_equ_0 = (r_cnt == '0);
        w_qbit      = s1 & ~r_lt_y;
    end

    // Divisor register and divide-by-zero flag, both captured on ld
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            div_by_zero <= 1'b0;
        end else if (ld) begin
            r_y         <= divisor;
            div_by_zero <= (divisor == '0);
        end
    end

    // Iteration counter: load 4 or 0, otherwise count up/down with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (ld) begin
            r_cnt <= s3 ? DW'(0) : DW'(4);
        end else if (ce) begin
            r_cnt <= ud ? (r_cnt + DW'(1)) : (r_cnt - DW'(1));
        end
    end

    // X: dividend in, quotient bits shifted in from the right
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
        end else if (ldx) begin
            r_x <= dividend;
        end else if (cex) begin
            r_x <= '0;
        end else if (slx) begin
            r_x <= {r_x[DW-2:0], w_qbit};
        end else if (srx) begin
            r_x <= {1'b0, r_x[DW-1:1]};
        end
    end

    // R: partial remainder; shift-left pulls in the pre-edge X MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= '0;
        end else if (ldr) begin
            r_r <= s2 ? w_r_sub : RW'(0);
        end else if (cer) begin
            r_r <= '0;
        end else if (slr) begin
            r_r <= {r_r[RW-2:0], r_x[DW-1]};
        end else if (srr) begin
            r_r <= {1'b0, r_r[RW-1:1]};
        end
    end

    // Result registers, updated only on the done strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (done) begin
            quotient  <= r_x;
            remainder <= r_r[DW-1:0];
        end
    end

endmodule

// File: doc/div_datapath.md
DIV_DATAPATH -- requirements
Module: div_datapath

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all storage updates on the rising edge of clk.
REQ-002 The ports SHALL be as follows:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- dividend  input  4  unsigned dividend
- divisor  input  4  unsigned divisor
- ld  input  1  load counter and Y register
- ud  input  1  counter direction: 1 = up, 0 = down
- ce  input  1  counter count enable
- ldx, slx, srx, cex  input  1 each  X register: load, shift left, shift right, clear
- ldr, slr, srr, cer  input  1 each  R register: load, shift left, shift right, clear
- s1  input  1  X shift-in select
- s2  input  1  R load-source select
- s3  input  1  counter load-value select
- done  input  1  result-valid strobe from the control unit
- r_lt_y  output  1  R < Y
- count_equ_0  output  1  counter == 0
- quotient  output  4  result quotient
- remainder  output  4  result remainder
- div_by_zero  output  1  divisor was 0 at the last ld

Function
REQ-003 Y (4b) SHALL load divisor when ld=1 and otherwise hold its value.
REQ-004 The counter (4b) SHALL behave as follows:
- ld=1: load 4'd4 if s3=0, or 4'd0 if s3=1.
- else ce=1: count +1 if ud=1, or -1 if ud=0, wrapping modulo 16 (0-1 -> 15, 15+1 -> 0).
- else: hold.
REQ-005 X (4b) SHALL obey this priority: ldx (load dividend) > cex (clear to 0) > slx > srx > hold.
- slx: X <= {X[2:0], qbit}, where qbit = ~r_lt_y if s1=1, else 0.
- srx: X <= {1'b0, X[3:1]}.
REQ-006 R (5b) SHALL obey this priority: ldr > cer (clear to 0) > slr > srr > hold.
- ldr with s2=0: R <= 0.
- ldr with s2=1: R <= R - {1'b0,Y}, truncated to 5 bits.
- slr: R <= {R[3:0], X[3]}, using X[3] sampled before the same-edge X update.
- srr: R <= {1'b0, R[4:1]}.
REQ-007 r_lt_y SHALL be combinational: 1 iff R < {1'b0,Y} as unsigned.
REQ-008 count_equ_0 SHALL be combinational: 1 iff counter == 0.
REQ-009 quotient and remainder SHALL be registered.
- On a cycle with done=1, they capture X and R[3:0].
- Otherwise they hold.
- The first capture is visible the cycle after done.
REQ-010 div_by_zero SHALL be registered.
- On ld=1 it is set to (divisor == 0).
- Otherwise it holds.
- The datapath SHALL still run normally when the divisor is 0; no special handling is added.
REQ-011 Simultaneous slx and srx SHALL resolve to slx; simultaneous slr and srr SHALL resolve to slr.
REQ-012 Control inputs SHALL need no handshake; each asserted input acts on exactly one edge.
REQ-013 All control inputs at 0 SHALL hold every register.

Reset
REQ-014 On rst=1 at a clock edge, the following SHALL go to 0 regardless of every other input, including mid-division:
- Y, counter, X, R, quotient, remainder, div_by_zero.
REQ-015 After reset, the combinational outputs SHALL be count_equ_0=1 and r_lt_y=0 (R=0, Y=0).

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset mid-operation: load dividend=9, divisor=2, then assert rst -> next cycle all registered outputs are 0 and count_equ_0=1.
- Full division 7/2: control sequence load, shift, then 4 iterations of compare/subtract/shift, then srr, then done -> quotient=3, remainder=1, div_by_zero=0.
- Full division 15/1 -> quotient=15, remainder=0.
- Full division 3/5 (dividend < divisor) -> quotient=0, remainder=3.
- Divisor 0: ld with divisor=0 -> div_by_zero=1 the next cycle; a subsequent ld with divisor=4 -> div_by_zero=0.
- Counter and register boundaries:
  - ld with s3=1, then ce with ud=0 -> count=15, count_equ_0=0.
  - ld with s3=0, then 4 cycles of ce with ud=0 -> count_equ_0=1.
  - slx and srx together with X=4'b0110, s1=0 -> X=4'b1100.
